// File: rtl/fifo_rdstage_pkg.sv
// fifo_rdstage shared constants and types.
// Used by the read stage top and its output buffer.
package fifo_rdstage_pkg;

  localparam int RDSTAGE_DEPTH = 2;
  localparam int LVL_W         = 2;

  typedef logic [LVL_W-1:0] lvl_t;

  // Slot a captured word lands in once this cycle's pop has shifted.
  // The result is only 0 or 1 whenever a capture is legal.
  function automatic logic slot_idx(input lvl_t lvl, input logic pop);
    return lvl[0] ^ pop;
  endfunction

endpackage

// File: rtl/fifo_rdstage_buf.sv
// fifo_rdstage_buf: 2-entry shift buffer, entry 0 is the head.
// Pop shifts entry 1 down; a same-cycle write goes to a post-shift slot.
module fifo_rdstage_buf
  import fifo_rdstage_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr,
  input  logic              wridx,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              pop,
  output logic [DWIDTH-1:0] head
);

  logic [DWIDTH-1:0] ent [RDSTAGE_DEPTH];

  // Shift on pop, then overlay the captured word; clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RDSTAGE_DEPTH; i++) ent[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < RDSTAGE_DEPTH; i++) ent[i] <= '0;
    end else begin
      if (pop) ent[0] <= ent[1];
      if (wr) ent[wridx] <= wdata;
    end
  end

  assign head = ent[0];

endmodule

// File: rtl/fifo_rdstage.sv
// fifo_rdstage: read-side output stage of the flushable FIFO.
// Optional parity check is enabled with the RDSTAGE_PAR_EN macro.
module fifo_rdstage
  import fifo_rdstage_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int RDLAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              notempty,
  output logic              fiford,
  output logic              fifofsh,
  input  logic [DWIDTH:0]   memdata,
  output logic [DWIDTH-1:0] dout,
  output logic              dvalid,
  input  logic              dready,
  output logic [1:0]        level,
  output logic              perr
);

  if (RDLAT != 1) begin : g_rdlat_chk
    $error("fifo_rdstage: only RDLAT = 1 is supported");
  end

  logic         inflt;
  logic         pop;
  logic         wr;
  logic [LVL_W:0] occ;
  lvl_t         lvl_nxt;

  assign pop     = dvalid & dready;
  assign fifofsh = flush;
  assign wr      = inflt & !flush;

  // Words held or arriving, minus the one leaving this cycle.
  assign occ = {1'b0, level} + {{LVL_W{1'b0}}, inflt}
             - {{LVL_W{1'b0}}, pop};

  assign fiford = !rst & notempty & !flush
                & (occ < (LVL_W+1)'(RDSTAGE_DEPTH));

  assign lvl_nxt = level + {{(LVL_W-1){1'b0}}, wr}
                 - {{(LVL_W-1){1'b0}}, pop};

  // Track the read in flight and the buffer fill level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflt  <= 1'b0;
      level  <= '0;
      dvalid <= 1'b0;
    end else begin
      inflt <= fiford & notempty;
      if (flush) begin
        level  <= '0;
        dvalid <= 1'b0;
      end else begin
        level  <= lvl_nxt;
        dvalid <= (lvl_nxt != '0);
      end
    end
  end

  fifo_rdstage_buf #(
    .DWIDTH(DWIDTH)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .wr   (wr),
    .wridx(slot_idx(level, pop)),
    .wdata(memdata[DWIDTH-1:0]),
    .pop  (pop),
    .head (dout)
  );

`ifdef RDSTAGE_PAR_EN
  // Sticky even-parity error over every captured word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr <= 1'b0;
    end else if (wr && (^memdata)) begin
      perr <= 1'b1;
    end
  end
`else
  logic unused_par;
  assign unused_par = memdata[DWIDTH];
  assign perr       = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rdstage.sv
// tb_fifo_rdstage: queue-based model of fifo_rdstage plus
// directed scenarios with literal expectations.
module tb_fifo_rdstage;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          notempty;
  logic          fiford;
  logic          fifofsh;
  logic [DW:0]   memdata;
  logic [DW-1:0] dout;
  logic          dvalid;
  logic          dready;
  logic [1:0]    level;
  logic          perr;

  always #5 clk = ~clk;

  fifo_rdstage #(
    .DWIDTH(DW),
    .RDLAT (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .notempty(notempty),
    .fiford  (fiford),
    .fifofsh (fifofsh),
    .memdata (memdata),
    .dout    (dout),
    .dvalid  (dvalid),
    .dready  (dready),
    .level   (level),
    .perr    (perr)
  );

  int checks = 0;
  int errors = 0;

  logic [DW:0]   cq [$];
  logic [DW:0]   nxt_md = '0;
  logic [DW-1:0] mq [$];
  logic          m_infl = 1'b0;
  logic [DW:0]   m_word = '0;
  logic          m_perr = 1'b0;
  logic [DW-1:0] got [$];
  logic [DW-1:0] exq [$];

  int cyc = 0;
  int first_rd = -1;
  int first_dv = -1;
  int first_pop = -1;
  int last_pop = -1;
  int n_rd = 0;
  int max_lvl = 0;

  function automatic logic [DW:0] w(input logic [DW-1:0] d);
    return {^d, d};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_got(input string nm);
    chk({nm, "_count"}, got.size(), exq.size());
    for (int i = 0; i < exq.size() && i < got.size(); i++)
      chk(nm, {24'h0, got[i]}, {24'h0, exq[i]});
  endtask

  task automatic step(input logic fl, input logic rdy);
    @(posedge clk);
    #1;
    flush    = fl;
    dready   = rdy;
    memdata  = nxt_md;
    notempty = (cq.size() != 0);
  endtask

  task automatic clr_log();
    got.delete();
    exq.delete();
    first_rd  = -1;
    first_dv  = -1;
    first_pop = -1;
    last_pop  = -1;
    n_rd      = 0;
    max_lvl   = 0;
  endtask

  // Model, controller and per-cycle compare, all on the falling edge.
  always @(negedge clk) begin
    logic        m_pop;
    logic        m_rd;
    int          occ;
    logic [DW:0] rdw;
    cyc++;
    if (rst) begin
      mq.delete();
      m_infl = 1'b0;
      m_perr = 1'b0;
      nxt_md = '0;
    end else begin
      m_pop = (mq.size() != 0) && dready;
      occ   = mq.size() + int'(m_infl) - int'(m_pop);
      m_rd  = notempty && !flush && (occ < 2);
      chk("fiford", fiford, m_rd);
      chk("fifofsh", fifofsh, flush);
      chk("dvalid", dvalid, mq.size() != 0);
      chk("level", level, mq.size());
      if (mq.size() != 0) chk("dout", dout, mq[0]);
      chk("perr", perr, m_perr);
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (fiford) begin
        n_rd++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (dvalid && first_dv < 0) first_dv = cyc;
      if (dvalid && dready && !flush) begin
        got.push_back(dout);
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      rdw = '0;
      if (flush) cq.delete();
      else if (fiford && cq.size() != 0) rdw = cq.pop_front();
      nxt_md = rdw;
      if (flush) begin
        mq.delete();
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_infl) begin
          mq.push_back(m_word[DW-1:0]);
`ifdef RDSTAGE_PAR_EN
          if (^m_word) m_perr = 1'b1;
`endif
        end
      end
      m_infl = m_rd;
      m_word = rdw;
    end
  end

  initial begin
    logic exp_perr;
`ifdef RDSTAGE_PAR_EN
    exp_perr = 1'b1;
`else
    exp_perr = 1'b0;
`endif
    rst      = 1'b1;
    flush    = 1'b0;
    dready   = 1'b0;
    notempty = 1'b1;
    memdata  = '0;

    #12;
    chk("rst_fiford", fiford, 0);
    chk("rst_dvalid", dvalid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_level", level, 0);
    chk("rst_perr", perr, 0);
    flush = 1'b1;
    #1;
    chk("rst_fifofsh", fifofsh, 1);
    flush    = 1'b0;
    notempty = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Streaming at full rate.
    clr_log();
    for (int i = 1; i <= 4; i++) begin
      cq.push_back(w(8'(i * 17)));
      exq.push_back(8'(i * 17));
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    chk("stream_nrd", n_rd, 4);
    chk("stream_lat", first_dv - first_rd, 2);
    chk("stream_popspan", last_pop - first_pop, 3);
    chk_got("stream_data");

    // Backpressure.
    clr_log();
    for (int i = 1; i <= 4; i++) begin
      cq.push_back(w(8'(i * 17)));
      exq.push_back(8'(i * 17));
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    #1;
    chk("bp_level", level, 2);
    chk("bp_fiford", fiford, 0);
    chk("bp_dout", dout, 8'h11);
    chk("bp_nrd", n_rd, 2);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
    chk_got("bp_data");

    // Flush with a read in flight.
    clr_log();
    cq.push_back(w(8'hA1));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    cq.push_back(w(8'hA2));
    step(1'b0, 1'b0);
    #1;
    chk("fl_rd", fiford, 1);
    chk("fl_lvl1", level, 1);
    step(1'b1, 1'b0);
    #1;
    chk("fl_fifofsh", fifofsh, 1);
    chk("fl_fiford", fiford, 0);
    step(1'b0, 1'b1);
    #1;
    chk("fl_dvalid", dvalid, 0);
    chk("fl_level", level, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    chk_got("fl_data");

    // Alternating ready on six words.
    clr_log();
    for (int i = 1; i <= 6; i++) begin
      cq.push_back(w(8'(8'h50 + i)));
      exq.push_back(8'(8'h50 + i));
    end
    for (int i = 0; i < 16; i++) step(1'b0, (i % 2) == 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    chk_got("alt_data");
    chk("alt_maxlvl", max_lvl <= 2, 1);

    // Asynchronous reset with a full buffer.
    clr_log();
    for (int i = 1; i <= 4; i++) cq.push_back(w(8'(8'h60 + i)));
    exq.push_back(8'h63);
    exq.push_back(8'h64);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    #1;
    chk("ar_lvl2", level, 2);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_dvalid", dvalid, 0);
    chk("ar_level", level, 0);
    chk("ar_dout", dout, 0);
    chk("ar_fiford", fiford, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
    chk_got("ar_data");

    // Bad parity word, then flush.
    clr_log();
    cq.push_back({1'b0, 8'h01});
    exq.push_back(8'h01);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    #1;
    chk("par_perr", perr, exp_perr);
    chk("par_dout", dout, 8'h01);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    #1;
    chk("par_perr_flush", perr, exp_perr);
    chk_got("par_data");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
